// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch front end with a small prefetch queue. It issues one
//   sequential word request at a time to a multi-cycle instruction memory,
//   buffers each returned word together with its PC+2, and hands the words to
//   decode under a valid/ready handshake. A redirect flushes the queue and
//   restarts fetching at a new PC. Halt stops fetching once no request is
//   outstanding.
//
// Parameters
//   DEPTH     queue entries (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   imem_req     out  request outstanding; held high until imem_done
//   imem_addr    out  word address of request; stable while imem_req
//   imem_done    in   response valid this cycle (ignored if !imem_req)
//   imem_data    in   instruction word, valid with imem_done
//   redirect_en  in   flush and refetch from redirect_pc
//   redirect_pc  in   target PC for redirect
//   halt         in   halt reached writeback: stop fetching
//   inst_valid   out  inst/pc_inc valid to decode
//   inst_ready   in   decode accepts (low = stall)
//   inst         out  instruction; 16'h0800 (NOP) when !inst_valid
//   pc_inc       out  PC of inst + 2
//   halted       out  fetch stopped by halt
//
// Configuration
//   FETCH_QUEUE_BYPASS_EN  when defined, a response arriving while the queue
//                          is empty (and no redirect) is driven straight to
//                          inst with inst_valid=1; if decode takes it that
//                          cycle it is not pushed. When undefined, every word
//                          passes through the queue and inst/inst_valid/pc_inc
//                          come straight from the head register.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_done,
   input  logic [15:0] imem_data,
   input  logic        redirect_en,
   input  logic [15:0] redirect_pc,
   input  logic        halt,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [15:0] inst,
   output logic [15:0] pc_inc,
   output logic        halted
);

   localparam int          CW  = $clog2(DEPTH) + 1;
   localparam logic [15:0] NOP = 16'h0800;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t        state_r, state_nx;
   logic          req_nx;
   logic [15:0]   addr_nx;
   logic [15:0]   fetch_pc_r, fetch_pc_nx;
   logic          discard_r, discard_nx;
   logic          halt_pend_r, halt_pend_nx;

   // Shift-register queue: entry 0 is always the head, valid bits are
   // contiguous from entry 0, and empty slots hold {NOP, 0} so the head
   // registers can drive the outputs directly.
   logic [15:0]      q_inst_r [DEPTH];
   logic [15:0]      q_pc_r   [DEPTH];
   logic [DEPTH-1:0] q_vld_r;
   logic [CW-1:0]    count_r;
   logic [15:0]      nq_inst_s [DEPTH];
   logic [15:0]      nq_pc_s   [DEPTH];
   logic [DEPTH-1:0] nq_vld_s;
   logic [CW-1:0]    count_nx;

   logic          flush_s;
   logic          done_s;
   logic          accept_s;
   logic          pop_s;
   logic          push_s;
   logic          byp_take_s;
   logic [CW-1:0] push_idx_s;
   logic [15:0]   addr_p2_s;

   // Redirects are ignored once halted; a response is only meaningful in WAIT.
   assign flush_s   = redirect_en & (state_r != S_HALT);
   assign done_s    = imem_done & (state_r == S_WAIT);
   assign accept_s  = done_s & ~discard_r & ~flush_s;
   assign addr_p2_s = imem_addr + 16'd2;

`ifdef FETCH_QUEUE_BYPASS_EN
   // The head is only free for the bypass word when nothing is queued; a
   // head that is being popped this cycle already occupies the outputs.
   logic byp_s;
   assign byp_s      = accept_s & (count_r == {CW{1'b0}});
   assign byp_take_s = byp_s & inst_ready;
   assign inst_valid = q_vld_r[0] | byp_s;
   assign inst       = byp_s ? imem_data : q_inst_r[0];
   assign pc_inc     = byp_s ? addr_p2_s : q_pc_r[0];
`else
   assign byp_take_s = 1'b0;
   assign inst_valid = q_vld_r[0];
   assign inst       = q_inst_r[0];
   assign pc_inc     = q_pc_r[0];
`endif

   assign pop_s      = q_vld_r[0] & inst_ready & ~flush_s;
   assign push_s     = accept_s & ~byp_take_s;
   assign push_idx_s = count_r - {{(CW-1){1'b0}}, pop_s};
   assign halted     = (state_r == S_HALT);

   // Fetch FSM next-state and request/PC bookkeeping.
   always_comb begin
      state_nx     = state_r;
      req_nx       = imem_req;
      addr_nx      = imem_addr;
      fetch_pc_nx  = fetch_pc_r;
      discard_nx   = discard_r;
      halt_pend_nx = halt_pend_r | (halt & (state_r != S_HALT));
      case (state_r)
         S_IDLE: begin
            if (halt | halt_pend_r) begin
               state_nx = S_HALT;
            end else begin
               if (flush_s) begin
                  fetch_pc_nx = redirect_pc;
               end else begin
                  fetch_pc_nx = fetch_pc_r;
               end
               // A flush empties the queue, so a slot is guaranteed.
               if (flush_s | (count_r < CW'(DEPTH))) begin
                  state_nx = S_WAIT;
                  req_nx   = 1'b1;
                  addr_nx  = flush_s ? redirect_pc : fetch_pc_r;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_WAIT: begin
            if (flush_s) begin
               fetch_pc_nx = redirect_pc;
            end else if (accept_s) begin
               fetch_pc_nx = addr_p2_s;
            end else begin
               fetch_pc_nx = fetch_pc_r;
            end
            if (done_s) begin
               req_nx     = 1'b0;
               discard_nx = 1'b0;
               state_nx   = S_IDLE;
            end else begin
               // Request cannot be aborted: remember to drop its response.
               discard_nx = discard_r | flush_s;
            end
         end
         S_HALT: begin
            req_nx = 1'b0;
         end
         default: begin
            state_nx = S_IDLE;
            req_nx   = 1'b0;
         end
      endcase
   end

   // Queue next contents: flush, else shift out the head, then append.
   always_comb begin
      nq_inst_s = q_inst_r;
      nq_pc_s   = q_pc_r;
      nq_vld_s  = q_vld_r;
      count_nx  = count_r;
      if (flush_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            nq_inst_s[i] = NOP;
            nq_pc_s[i]   = 16'h0000;
         end
         nq_vld_s = {DEPTH{1'b0}};
         count_nx = {CW{1'b0}};
      end else begin
         if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               nq_inst_s[i] = q_inst_r[i+1];
               nq_pc_s[i]   = q_pc_r[i+1];
               nq_vld_s[i]  = q_vld_r[i+1];
            end
            nq_inst_s[DEPTH-1] = NOP;
            nq_pc_s[DEPTH-1]   = 16'h0000;
            nq_vld_s[DEPTH-1]  = 1'b0;
         end else begin
            nq_vld_s = q_vld_r;
         end
         if (push_s) begin
            for (int i = 0; i < DEPTH; i++) begin
               nq_inst_s[i] = (CW'(i) == push_idx_s) ? imem_data : nq_inst_s[i];
               nq_pc_s[i]   = (CW'(i) == push_idx_s) ? addr_p2_s : nq_pc_s[i];
               nq_vld_s[i]  = (CW'(i) == push_idx_s) ? 1'b1      : nq_vld_s[i];
            end
         end else begin
            nq_vld_s = nq_vld_s;
         end
         count_nx = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
      end
   end

   // State, request and queue registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         fetch_pc_r  <= RESET_PC;
         discard_r   <= 1'b0;
         halt_pend_r <= 1'b0;
         q_vld_r     <= {DEPTH{1'b0}};
         count_r     <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            q_inst_r[i] <= NOP;
            q_pc_r[i]   <= 16'h0000;
         end
      end else begin
         state_r     <= state_nx;
         imem_req    <= req_nx;
         imem_addr   <= addr_nx;
         fetch_pc_r  <= fetch_pc_nx;
         discard_r   <= discard_nx;
         halt_pend_r <= halt_pend_nx;
         q_vld_r     <= nq_vld_s;
         count_r     <= count_nx;
         q_inst_r    <= nq_inst_s;
         q_pc_r      <= nq_pc_s;
      end
   end

endmodule
